// File: rtl/mem_req_mshr_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_mshr_queue
// Purpose  : Request FIFO feeding a registered output stage that tags each
//            issued memory request with a free MSHR id from a small pool.
//            Ids are returned to the pool when the matching response arrives.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_mshr_queue #(
  parameter int         DEPTH     = 4,
  parameter int         NUM_MSHR  = 4,
  parameter logic [7:0] MSHR_BASE = 8'd144,
  parameter int         ADDR_W    = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  // request input from the parser
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_req_type,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [7:0]        in_write_mask,
  input  logic [31:0]       in_data_0,
  input  logic [31:0]       in_data_1,
  // issued request towards the encoder
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_req_type,
  output logic [1:0]        out_size,
  output logic [ADDR_W-1:0] out_address,
  output logic [7:0]        out_write_mask,
  output logic [31:0]       out_data_0,
  output logic [31:0]       out_data_1,
  output logic [7:0]        out_mshrid,
  // response return path
  input  logic              resp_valid,
  input  logic [7:0]        resp_mshrid,
  output logic [3:0]        outstanding,
  output logic              err_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam int ENT_W = 8 + 2 + ADDR_W + 8 + 32 + 32;

  typedef enum logic [0:0] {
    O_EMPTY = 1'b0,
    O_FULL  = 1'b1
  } out_state_e;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]    fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // output register
  out_state_e          state_q, state_d;
  logic [ENT_W-1:0]    out_entry_q, out_entry_d;
  logic [7:0]          out_mshrid_q, out_mshrid_d;

  // MSHR pool
  logic [NUM_MSHR-1:0] bitmap_q, bitmap_d;
  logic                err_resp_q, err_resp_d;

  // combinational helpers
  logic                push;
  logic                load;
  logic                handshake;
  logic                fifo_nonempty;
  logic                any_free;
  logic [IDX_W-1:0]    alloc_idx;
  logic [NUM_MSHR-1:0] alloc_mask;
  logic [NUM_MSHR-1:0] free_mask;
  logic                resp_hit;
  logic [7:0]          resp_off;
  logic [3:0]          popcount;
  logic [ENT_W-1:0]    in_entry;

  // Entry layout shared by the FIFO and the output register
  assign in_entry = {in_req_type, in_size, in_address, in_write_mask,
                     in_data_0, in_data_1};

  // Ready is held low during reset so nothing is captured while clearing
  assign in_ready      = rst_n & (count_q < CNT_W'(DEPTH));
  assign push          = in_valid & in_ready;
  assign fifo_nonempty = (count_q != '0);
  assign handshake     = (state_q == O_FULL) & out_ready;
  // Load only with a free id; an occupied register must be drained this cycle
  assign load          = fifo_nonempty & any_free &
                         ((state_q == O_EMPTY) | out_ready);

  // Pick the lowest clear bit of the registered bitmap
  always_comb begin
    any_free   = 1'b0;
    alloc_idx  = '0;
    alloc_mask = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (!bitmap_q[i] && !any_free) begin
        any_free      = 1'b1;
        alloc_idx     = IDX_W'(i);
        alloc_mask[i] = 1'b1;
      end
    end
  end

  // Decode the response id against the pool; modular offset covers both range ends
  always_comb begin
    resp_off  = resp_mshrid - MSHR_BASE;
    resp_hit  = 1'b0;
    free_mask = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (resp_valid && (resp_off == 8'(i)) && bitmap_q[i]) begin
        resp_hit     = 1'b1;
        free_mask[i] = 1'b1;
      end
    end
  end

  // Bitmap update: a freed id only becomes allocatable on the following cycle
  always_comb begin
    bitmap_d   = bitmap_q & ~free_mask;
    if (load) begin
      bitmap_d = bitmap_d | alloc_mask;
    end
    err_resp_d = resp_valid & ~resp_hit;
  end

  // FIFO pointer and occupancy update; pop happens exactly on a load
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push, load})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output stage next state: load wins over a plain drain
  always_comb begin
    state_d      = state_q;
    out_entry_d  = out_entry_q;
    out_mshrid_d = out_mshrid_q;
    rd_ptr_d     = rd_ptr_q;
    if (load) begin
      state_d      = O_FULL;
      out_entry_d  = fifo_mem_q[rd_ptr_q];
      out_mshrid_d = MSHR_BASE + 8'(alloc_idx);
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
    end else if (handshake) begin
      state_d      = O_EMPTY;
    end
  end

  // Number of ids currently in flight
  always_comb begin
    popcount = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (bitmap_q[i]) begin
        popcount = popcount + 4'd1;
      end
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= O_EMPTY;
      out_entry_q  <= '0;
      out_mshrid_q <= '0;
      bitmap_q     <= '0;
      err_resp_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      out_entry_q  <= out_entry_d;
      out_mshrid_q <= out_mshrid_d;
      bitmap_q     <= bitmap_d;
      err_resp_q   <= err_resp_d;
    end
  end

  // FIFO payload storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign out_valid   = (state_q == O_FULL);
  assign {out_req_type, out_size, out_address, out_write_mask,
          out_data_0, out_data_1} = out_entry_q;
  assign out_mshrid  = out_mshrid_q;
  assign outstanding = popcount;
  assign err_resp    = err_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_mshr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_mshr_queue
// Purpose  : Scoreboard bench for mem_req_mshr_queue. Accepted requests are
//            queued with their fields; each output handshake pops and checks
//            fields and the id the scenario expects.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_mshr_queue;

  localparam int ADDR_W = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_req_type;
  logic [1:0]        in_size;
  logic [ADDR_W-1:0] in_address;
  logic [7:0]        in_write_mask;
  logic [31:0]       in_data_0;
  logic [31:0]       in_data_1;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_req_type;
  logic [1:0]        out_size;
  logic [ADDR_W-1:0] out_address;
  logic [7:0]        out_write_mask;
  logic [31:0]       out_data_0;
  logic [31:0]       out_data_1;
  logic [7:0]        out_mshrid;
  logic              resp_valid;
  logic [7:0]        resp_mshrid;
  logic [3:0]        outstanding;
  logic              err_resp;

  typedef struct packed {
    logic [7:0]        req_type;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mask;
    logic [31:0]       d0;
    logic [31:0]       d1;
  } req_t;

  req_t       exp_q[$];
  logic [7:0] id_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  req_t       mon_got;
  req_t       mon_want;
  logic [7:0] mon_wid;

  mem_req_mshr_queue #(
    .DEPTH(4), .NUM_MSHR(4), .MSHR_BASE(8'd144), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_req_type(in_req_type), .in_size(in_size), .in_address(in_address),
    .in_write_mask(in_write_mask), .in_data_0(in_data_0), .in_data_1(in_data_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_req_type(out_req_type), .out_size(out_size), .out_address(out_address),
    .out_write_mask(out_write_mask), .out_data_0(out_data_0), .out_data_1(out_data_1),
    .out_mshrid(out_mshrid),
    .resp_valid(resp_valid), .resp_mshrid(resp_mshrid),
    .outstanding(outstanding), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  function automatic req_t mk_req(input int k);
    req_t r;
    r.req_type = 8'(8'h10 + k);
    r.size     = 2'(k);
    r.addr     = ADDR_W'(40'h2_0000 + 40'(k) * 40'h40);
    r.mask     = 8'(k * 3 + 1);
    r.d0       = 32'(32'hA500_0000 + k);
    r.d1       = ~r.d0 ^ 32'(k << 8);
    return r;
  endfunction

  task automatic drive(input req_t r);
    in_valid      = 1'b1;
    in_req_type   = r.req_type;
    in_size       = r.size;
    in_address    = r.addr;
    in_write_mask = r.mask;
    in_data_0     = r.d0;
    in_data_1     = r.d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted pushes, check every completed handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        mon_got = {out_req_type, out_size, out_address, out_write_mask,
                   out_data_0, out_data_1};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_fields: unexpected output addr=%h, expected no output", out_address);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            n_fail++;
            $display("FAIL sb_fields: got %h, expected %h", mon_got, mon_want);
          end
        end
        n_checks++;
        if (id_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_mshrid: got %0d, expected no output", out_mshrid);
        end else begin
          mon_wid = id_q.pop_front();
          if (out_mshrid !== mon_wid) begin
            n_fail++;
            $display("FAIL sb_mshrid: got %0d, expected %0d", out_mshrid, mon_wid);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_req_type, in_size, in_address, in_write_mask,
                         in_data_0, in_data_1});
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d, expected 0", outstanding); end
    n_checks++; if (err_resp !== 1'b0) begin n_fail++; $display("FAIL reset_err_resp: got %b, expected 0", err_resp); end
    n_checks++; if (out_address !== '0 || out_mshrid !== 8'd0) begin n_fail++; $display("FAIL reset_fields: got addr=%h id=%0d, expected 0/0", out_address, out_mshrid); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_single();
    req_t r;
    tick();
    out_ready = 1'b1;
    r = {8'h02, 2'b11, 40'h10_00, 8'hff, 32'hdeadbeef, 32'hbeefdead};
    id_q.push_back(8'd144);
    drive(r);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got out_valid=%b, expected 0", out_valid); end
    tick();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got out_valid=%b, expected 1", out_valid); end
    n_checks++; if (out_address !== 40'h1000 || out_mshrid !== 8'd144) begin n_fail++; $display("FAIL single_fields: got addr=%h id=%0d, expected 1000/144", out_address, out_mshrid); end
    tick();
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d, expected 1", outstanding); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got out_valid=%b, expected 0", out_valid); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd144;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd0 || err_resp !== 1'b0) begin n_fail++; $display("FAIL single_free: got outstanding=%0d err=%b, expected 0/0", outstanding, err_resp); end
  endtask

  task automatic test_back_to_back();
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) id_q.push_back(8'(144 + k));
    id_q.push_back(8'd145);
    for (int k = 0; k < 5; k++) begin
      drive(mk_req(k));
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd4) begin n_fail++; $display("FAIL b2b_outstanding: got %0d, expected 4", outstanding); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got out_valid=%b, expected 0", out_valid); end
    n_checks++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL b2b_held: got %0d pending, expected 1", exp_q.size()); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd145;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || outstanding !== 4'd3) begin n_fail++; $display("FAIL b2b_free_visible: got out_valid=%b outstanding=%0d, expected 0/3", out_valid, outstanding); end
    tick();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_mshrid !== 8'd145) begin n_fail++; $display("FAIL b2b_reissue: got out_valid=%b id=%0d, expected 1/145", out_valid, out_mshrid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1; resp_mshrid = 8'(144 + i);
      tick();
    end
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd0 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_final: got outstanding=%0d pending=%0d, expected 0/0", outstanding, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int   k;
    logic acc;
    logic snap_ok;
    req_t snap;
    req_t cur;
    logic [7:0] snap_id;
    k = 0;
    snap_ok = 1'b0;
    snap = '0;
    snap_id = '0;
    tick();
    out_ready = 1'b0;
    id_q.push_back(8'd144); id_q.push_back(8'd145); id_q.push_back(8'd146);
    id_q.push_back(8'd147); id_q.push_back(8'd144);
    for (int c = 0; c < 10; c++) begin
      if (k < 6) drive(mk_req(10 + k)); else in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid) begin
        cur = {out_req_type, out_size, out_address, out_write_mask, out_data_0, out_data_1};
        if (!snap_ok) begin
          snap = cur; snap_id = out_mshrid; snap_ok = 1'b1;
          n_checks++; if (cur !== mk_req(10) || out_mshrid !== 8'd144) begin n_fail++; $display("FAIL bp_first: got %h id=%0d, expected %h id=144", cur, out_mshrid, mk_req(10)); end
        end else begin
          n_checks++; if (cur !== snap || out_mshrid !== snap_id) begin n_fail++; $display("FAIL bp_stable: got %h id=%0d, expected %h id=%0d", cur, out_mshrid, snap, snap_id); end
        end
      end
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d, expected 5", k); end
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: got in_ready=%b out_valid=%b, expected 0/1", in_ready, out_valid); end
    tick();
    out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd4 || exp_q.size() != 1) begin n_fail++; $display("FAIL bp_release: got outstanding=%0d pending=%0d, expected 4/1", outstanding, exp_q.size()); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd144;
    tick();
    resp_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, expected 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1; resp_mshrid = 8'(144 + i);
      tick();
    end
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL bp_free: got %0d, expected 0", outstanding); end
  endtask

  task automatic test_err_resp();
    tick();
    out_ready = 1'b1;
    id_q.push_back(8'd144);
    drive(mk_req(20));
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL err_setup: got %0d, expected 1", outstanding); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd150;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (err_resp !== 1'b1 || outstanding !== 4'd1) begin n_fail++; $display("FAIL err_out_of_range: got err=%b outstanding=%0d, expected 1/1", err_resp, outstanding); end
    tick();
    @(negedge clk);
    n_checks++; if (err_resp !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b, expected 0", err_resp); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd146;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (err_resp !== 1'b1 || outstanding !== 4'd1) begin n_fail++; $display("FAIL err_unallocated: got err=%b outstanding=%0d, expected 1/1", err_resp, outstanding); end
    tick();
    @(negedge clk);
    n_checks++; if (err_resp !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width2: got %b, expected 0", err_resp); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd144;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (err_resp !== 1'b0 || outstanding !== 4'd0) begin n_fail++; $display("FAIL err_good_resp: got err=%b outstanding=%0d, expected 0/0", err_resp, outstanding); end
  endtask

  task automatic test_same_cycle();
    tick();
    out_ready = 1'b0;
    id_q.push_back(8'd144); id_q.push_back(8'd145);
    drive(mk_req(30));
    tick();
    drive(mk_req(31));
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_mshrid !== 8'd144 || outstanding !== 4'd1) begin n_fail++; $display("FAIL same_setup: got valid=%b id=%0d outstanding=%0d, expected 1/144/1", out_valid, out_mshrid, outstanding); end
    tick();
    out_ready = 1'b1; resp_valid = 1'b1; resp_mshrid = 8'd144;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_mshrid !== 8'd145) begin n_fail++; $display("FAIL same_new_id: got valid=%b id=%0d, expected 1/145", out_valid, out_mshrid); end
    n_checks++; if (outstanding !== 4'd1 || err_resp !== 1'b0) begin n_fail++; $display("FAIL same_net: got outstanding=%0d err=%b, expected 1/0", outstanding, err_resp); end
    tick();
    resp_valid = 1'b1; resp_mshrid = 8'd145;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd0 || exp_q.size() != 0) begin n_fail++; $display("FAIL same_final: got outstanding=%0d pending=%0d, expected 0/0", outstanding, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    tick();
    out_ready = 1'b1;
    id_q.push_back(8'd144); id_q.push_back(8'd145);
    drive(mk_req(40));
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    drive(mk_req(41)); tick();
    drive(mk_req(42)); tick();
    drive(mk_req(43)); tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got outstanding=%0d valid=%b, expected 2/1", outstanding, out_valid); end
    tick();
    rst_n = 1'b0; out_ready = 1'b1;
    tick();
    exp_q.delete();
    id_q.delete();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || outstanding !== 4'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset: got valid=%b outstanding=%0d in_ready=%b, expected 0/0/0", out_valid, outstanding, in_ready); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || outstanding !== 4'd0) begin n_fail++; $display("FAIL rmid_after: got valid=%b outstanding=%0d, expected 0/0", out_valid, outstanding); end
    tick();
    id_q.push_back(8'd144);
    drive(mk_req(50));
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_drain: got %0d pending, expected 0", exp_q.size()); end
    @(negedge clk);
    n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL rmid_outstanding: got %0d, expected 1", outstanding); end
  endtask

  initial begin
    in_valid      = 1'b0;
    in_req_type   = '0;
    in_size       = '0;
    in_address    = '0;
    in_write_mask = '0;
    in_data_0     = '0;
    in_data_1     = '0;
    out_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_mshrid   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_err_resp();
    test_same_cycle();
    test_reset_mid();
    n_checks++;
    if (id_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_ids: got %0d unissued, expected 0", id_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
